psg_ecfs_lvdcdc_sd_adc_integ: RTL
=================================

PSG_ECFS_LVDCDC_SD_ADC_INTEG -- requirements
Module: psg_ecfs_lvdcdc_sd_adc_integ

Interface
REQ-001 SHALL have parameter STUCK_LIMIT, default 1023: number of clk cycles without a modulator-data transition before a stuck fault is declared.
REQ-002 SHALL have clk input, 1 bit: ADC modulator clock; all logic is on its rising edge.
REQ-003 SHALL have reset_n input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have enable input, 1 bit: run control; low freezes integrators and the decimation counter.
REQ-005 SHALL have mdat input, 1 bit: sigma-delta modulator bitstream.
REQ-006 SHALL have sync input, 1 bit: single-cycle pulse that realigns the decimation phase across channels.
REQ-007 SHALL have fault_clr input, 1 bit: single-cycle pulse that clears the sticky stuck fault.
REQ-008 SHALL have cn_out output, 22 bits: third-integrator accumulator, feeding the downstream differentiator cn_in.
REQ-009 SHALL have cnr128 output, 1 bit: decimation strobe, one clk cycle wide, feeding the downstream differentiator.
REQ-010 SHALL have stuck_fault output, 1 bit: sticky flag indicating the bitstream is not toggling.

Function
REQ-011 SHALL capture mdat through a two-flop register chain, d1 then d2; x = d2, treated as an unsigned 0/1 value.
REQ-012 SHALL update, when enable=1, each cycle: acc1 <= acc1 + x; acc2 <= acc2 + acc1; acc3 <= acc3 + acc2, all using pre-edge values.
REQ-013 SHALL keep all accumulators 22 bits unsigned, wrapping modulo 2^22 with no saturation and no overflow flag.
REQ-014 SHALL drive cn_out = acc3 directly from a register, with no extra output stage; mdat-to-acc1 latency is 3 cycles.
REQ-015 SHALL hold acc1-3 and the decimation counter when enable=0; cnr128 SHALL be 0 while enable=0.
REQ-016 SHALL run a 7-bit decimation counter 0..127 when enable=1, wrapping from 127 to 0.
REQ-017 SHALL assert cnr128 for exactly one cycle, registered, in the cycle after the counter equals 127, giving a period of 128 cycles.
REQ-018 SHALL, when sync=1, load the counter with 0 on the next edge and suppress any cnr128 due from that cycle; sync wins over the terminal count.
REQ-019 SHALL honour sync even when enable=0.
REQ-020 SHALL NOT clear the integrators on sync.
REQ-021 SHALL keep a d2 history bit d3 and a 10-bit saturating run counter: d2≠d3 clears the counter to 0; otherwise the counter increments, saturating at 1023.
REQ-022 SHALL set stuck_fault on the edge where the run counter reaches STUCK_LIMIT; the flag is sticky.
REQ-023 SHALL clear stuck_fault on fault_clr; when fault_clr coincides with a set condition, set wins.
REQ-024 SHALL run the stuck detector independently of enable.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear d1, d2, d3, acc1-3, the decimation counter, the run counter, cn_out, cnr128 and stuck_fault to 0.
REQ-026 SHALL treat reset mid-operation as discarding all accumulator state; the first cnr128 after release occurs 128 enabled cycles later.

Structure
REQ-027 SHALL place ACC_W=22, DEC_W=7 and RUN_W=10 in the shared package psg_ecfs_lvdcdc_sd_adc_pkg.
REQ-028 SHALL implement each integrator as sub-module psg_ecfs_lvdcdc_sd_adc_integ_stage (width ACC_W, inputs en and din, registered accumulator output), instantiated three times.
REQ-029 SHALL keep the decimation counter, synchroniser and stuck detector in the top module.

Verification
REQ-030 SHALL cover: mdat=1 constant, enable=1; after the 10th edge with x=1 -> acc1=10, acc2=45, cn_out=120.
REQ-031 SHALL cover: mdat=0 constant, enable=1 -> cn_out stays 0; cnr128 pulses every 128 cycles; stuck_fault rises exactly 1023 cycles after d2 settles.
REQ-032 SHALL cover: mdat alternating 1,0 for 10000 cycles -> stuck_fault stays 0; at each cnr128, the cn_out difference against a reference model is 0, including across 2^22 wrap.
REQ-033 SHALL cover: sync pulsed when the counter is 50 -> no pulse at the old phase; next cnr128 exactly 128 cycles after the sync edge; also sync at count 127 -> that pulse is suppressed.
REQ-034 SHALL cover: enable dropped for 37 cycles mid-frame -> accumulators and counter frozen; cnr128 delayed by exactly 37 cycles.
REQ-035 SHALL cover: fault_clr coincident with the saturated run count -> stuck_fault stays 1; fault_clr after one mdat toggle -> stuck_fault 0; reset_n pulsed mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/psg_ecfs_lvdcdc_sd_adc_pkg.sv
// Shared widths for the LV DC-DC sigma-delta ADC integrator slice.
package psg_ecfs_lvdcdc_sd_adc_pkg;

    localparam int unsigned ACC_W = 22;
    localparam int unsigned DEC_W = 7;
    localparam int unsigned RUN_W = 10;

endpackage

// File: rtl/psg_ecfs_lvdcdc_sd_adc_integ_stage.sv
// One integrator stage of the CIC sinc3 front end: wrapping accumulator, frozen when en is low.
module psg_ecfs_lvdcdc_sd_adc_integ_stage
    import psg_ecfs_lvdcdc_sd_adc_pkg::*;
#(
    parameter int unsigned W = ACC_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    logic [W-1:0] r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + din;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/psg_ecfs_lvdcdc_sd_adc_integ.sv
// Sigma-delta ADC integrator chain: mdat synchroniser, three integrators, /128 decimation
// strobe for the downstream differentiator, and a sticky stuck-bitstream detector.
module psg_ecfs_lvdcdc_sd_adc_integ
    import psg_ecfs_lvdcdc_sd_adc_pkg::*;
#(
    parameter int unsigned STUCK_LIMIT = 1023
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mdat,
    input  logic             sync,
    input  logic             fault_clr,
    output logic [ACC_W-1:0] cn_out,
    output logic             cnr128,
    output logic             stuck_fault
);

    localparam logic [RUN_W-1:0] LP_LIMIT = RUN_W'(STUCK_LIMIT);

    logic             r_d1, r_d2, r_d3;
    logic [DEC_W-1:0] r_dec;
    logic             r_cnr;
    logic [RUN_W-1:0] r_run;
    logic             r_stuck;
    logic [RUN_W-1:0] w_run_nxt;
    logic             w_stuck_set;
    logic [ACC_W-1:0] w_x, w_acc1, w_acc2, w_acc3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1 <= 1'b0;
            r_d2 <= 1'b0;
            r_d3 <= 1'b0;
        end else begin
            r_d1 <= mdat;
            r_d2 <= r_d1;
            r_d3 <= r_d2;
        end
    end

    assign w_x = {{(ACC_W-1){1'b0}}, r_d2};

    psg_ecfs_lvdcdc_sd_adc_integ_stage #(.W(ACC_W)) u_int1 (
        .clk(clk), .reset_n(reset_n), .en(enable), .din(w_x),    .acc(w_acc1)
    );
    psg_ecfs_lvdcdc_sd_adc_integ_stage #(.W(ACC_W)) u_int2 (
        .clk(clk), .reset_n(reset_n), .en(enable), .din(w_acc1), .acc(w_acc2)
    );
    psg_ecfs_lvdcdc_sd_adc_integ_stage #(.W(ACC_W)) u_int3 (
        .clk(clk), .reset_n(reset_n), .en(enable), .din(w_acc2), .acc(w_acc3)
    );

    // sync takes priority over the terminal count and works regardless of enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dec <= '0;
            r_cnr <= 1'b0;
        end else if (sync) begin
            r_dec <= '0;
            r_cnr <= 1'b0;
        end else if (enable) begin
            r_dec <= r_dec + 1'b1;
            r_cnr <= (r_dec == '1);
        end else begin
            r_cnr <= 1'b0;
        end
    end

    always_comb begin
        w_run_nxt = r_run;
        if (r_d2 != r_d3) begin
            w_run_nxt = '0;
        end else if (r_run != '1) begin
            w_run_nxt = r_run + 1'b1;
        end
    end

    // Level compare keeps the set condition asserted while the run count sits saturated
    assign w_stuck_set = (w_run_nxt >= LP_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run   <= '0;
            r_stuck <= 1'b0;
        end else begin
            r_run <= w_run_nxt;
            if (w_stuck_set) begin
                r_stuck <= 1'b1;
            end else if (fault_clr) begin
                r_stuck <= 1'b0;
            end
        end
    end

    assign cn_out      = w_acc3;
    assign cnr128      = r_cnr;
    assign stuck_fault = r_stuck;

endmodule
